scoot_motor_driver: RTL and testbench

- Downstream stage of the evolved scoot controller. Consumes its 4 raw, glitch-prone, gate-delayed command bits and produces clean per-wheel PWM plus direction.
- Synchronises and glitch-filters the commands.
- Runs one soft-start and dead-time FSM per wheel so evolved controllers cannot slam motors or reverse instantly.

---
 rtl/scoot_drive_pkg.sv | 16 +
 rtl/scoot_motor_channel.sv | 125 ++++++++++++
 rtl/scoot_motor_driver.sv | 95 +++++++++
 tb/tb_scoot_motor_driver.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scoot_drive_pkg.sv
// rtl/scoot_drive_pkg.sv - shared wheel FSM state type and command bit positions for the scoot motor driver.
package scoot_drive_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    RUN,
    DEAD
  } state_t;

  localparam int CMD_L_EN  = 0;
  localparam int CMD_L_DIR = 1;
  localparam int CMD_R_EN  = 2;
  localparam int CMD_R_DIR = 3;

endpackage

// File: rtl/scoot_motor_channel.sv
// rtl/scoot_motor_channel.sv - one wheel: soft-start ramp, dead-time reversal FSM and PWM compare.
// Brake outputs are driven only when SCOOT_MOTOR_BRAKE_EN is defined; otherwise brake is tied 0.
module scoot_motor_channel
  import scoot_drive_pkg::*;
#(
  parameter int PWM_BITS  = 8,
  parameter int RAMP_STEP = 32,
  parameter int DEAD_TIME = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                dir,
  input  logic [PWM_BITS-1:0] cnt,
  input  logic                wrap,
  output logic                pwm,
  output logic                motor_dir,
  output logic                brake,
  output logic                moving
);

  localparam logic [PWM_BITS-1:0] MAX = '1;
  localparam int DW = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;
  localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_TIME - 1);

  state_t              state, state_next;
  logic [PWM_BITS-1:0] duty, duty_next;
  logic                dir_q, dir_q_next;
  logic [DW-1:0]       dead_cnt, dead_next;
  logic [PWM_BITS:0]   duty_sum;
  logic [PWM_BITS-1:0] duty_sat;
  logic                pwm_raw;

  // Widened add so the ramp saturates at MAX instead of wrapping.
  assign duty_sum = {1'b0, duty} + (PWM_BITS + 1)'(RAMP_STEP);
  assign duty_sat = (duty_sum > {1'b0, MAX}) ? MAX : duty_sum[PWM_BITS-1:0];

  always_comb begin
    state_next = state;
    duty_next  = duty;
    dir_q_next = dir_q;
    dead_next  = dead_cnt;
    case (state)
      IDLE: begin
        duty_next = '0;
        if (en) begin
          state_next = RAMP;
          dir_q_next = dir;
        end
      end
      RAMP, RUN: begin
        if (!en) begin
          state_next = IDLE;
          duty_next  = '0;
        end else if (dir != dir_q) begin
          state_next = DEAD;
          duty_next  = '0;
          dead_next  = DEAD_LOAD;
        end else if (state == RAMP && wrap) begin
          duty_next = duty_sat;
          if (duty_sat == MAX) state_next = RUN;
        end
      end
      DEAD: begin
        duty_next = '0;
        if (dead_cnt == '0) begin
          if (en) begin
            state_next = RAMP;
            dir_q_next = dir;
          end else begin
            state_next = IDLE;
          end
        end else begin
          dead_next = dead_cnt - DW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      duty     <= '0;
      dir_q    <= 1'b0;
      dead_cnt <= '0;
    end else begin
      state    <= state_next;
      duty     <= duty_next;
      dir_q    <= dir_q_next;
      dead_cnt <= dead_next;
    end
  end

  assign pwm_raw   = (duty == MAX) || (cnt < duty);
  assign motor_dir = dir_q;
  assign moving    = (state == RAMP) || (state == RUN);

`ifdef SCOOT_MOTOR_BRAKE_EN
  logic [PWM_BITS:0] brake_cnt;
  logic              to_idle;

  // Brake holds for one full PWM period after a drive-to-idle stop.
  assign to_idle = ((state == RAMP) || (state == RUN)) && !en;

  always_ff @(posedge clk) begin
    if (reset) begin
      brake_cnt <= '0;
    end else if (to_idle) begin
      brake_cnt <= {1'b1, {PWM_BITS{1'b0}}};
    end else if (state_next != IDLE) begin
      brake_cnt <= '0;
    end else if (brake_cnt != '0) begin
      brake_cnt <= brake_cnt - (PWM_BITS + 1)'(1);
    end
  end

  assign brake = (state == DEAD) || (brake_cnt != '0);
  assign pwm   = pwm_raw && !brake;
`else
  assign brake = 1'b0;
  assign pwm   = pwm_raw;
`endif

endmodule

// File: rtl/scoot_motor_driver.sv
// rtl/scoot_motor_driver.sv - command synchroniser, settle filter, shared PWM counter and two wheel channels.
// Optional brake feature: SCOOT_MOTOR_BRAKE_EN.
module scoot_motor_driver
  import scoot_drive_pkg::*;
#(
  parameter int PWM_BITS  = 8,
  parameter int SETTLE    = 4,
  parameter int RAMP_STEP = 32,
  parameter int DEAD_TIME = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cmd,
  output logic       left_pwm,
  output logic       left_dir,
  output logic       right_pwm,
  output logic       right_dir,
  output logic       left_brake,
  output logic       right_brake,
  output logic [1:0] moving
);

  localparam int SW = $clog2(SETTLE + 1);

  logic [3:0]          sync_a, cmd_sync, cmd_last, cmd_filt;
  logic [SW-1:0]       settle, run_len;
  logic [PWM_BITS-1:0] cnt;
  logic                wrap;
  logic                left_moving, right_moving;

  // Length of the current run of identical synchronised values, including this cycle.
  assign run_len = (cmd_sync == cmd_last) ? settle + SW'(1) : SW'(1);
  assign wrap    = (cnt == '1);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a   <= '0;
      cmd_sync <= '0;
      cmd_last <= '0;
      cmd_filt <= '0;
      settle   <= '0;
      cnt      <= '0;
    end else begin
      sync_a   <= cmd;
      cmd_sync <= sync_a;
      cmd_last <= cmd_sync;
      cnt      <= cnt + PWM_BITS'(1);
      if (cmd_sync == cmd_filt) begin
        settle <= '0;
      end else if (run_len >= SW'(SETTLE)) begin
        cmd_filt <= cmd_sync;
        settle   <= '0;
      end else begin
        settle <= run_len;
      end
    end
  end

  scoot_motor_channel #(
    .PWM_BITS (PWM_BITS),
    .RAMP_STEP(RAMP_STEP),
    .DEAD_TIME(DEAD_TIME)
  ) u_left (
    .clk      (clk),
    .reset    (reset),
    .en       (cmd_filt[CMD_L_EN]),
    .dir      (cmd_filt[CMD_L_DIR]),
    .cnt      (cnt),
    .wrap     (wrap),
    .pwm      (left_pwm),
    .motor_dir(left_dir),
    .brake    (left_brake),
    .moving   (left_moving)
  );

  scoot_motor_channel #(
    .PWM_BITS (PWM_BITS),
    .RAMP_STEP(RAMP_STEP),
    .DEAD_TIME(DEAD_TIME)
  ) u_right (
    .clk      (clk),
    .reset    (reset),
    .en       (cmd_filt[CMD_R_EN]),
    .dir      (cmd_filt[CMD_R_DIR]),
    .cnt      (cnt),
    .wrap     (wrap),
    .pwm      (right_pwm),
    .motor_dir(right_dir),
    .brake    (right_brake),
    .moving   (right_moving)
  );

  assign moving = {right_moving, left_moving};

endmodule

// File: tb/tb_scoot_motor_driver.sv
// tb/tb_scoot_motor_driver.sv - directed vector table, ramp/reset sequences and random stimulus against a reference model.
module tb_scoot_motor_driver;

  localparam int PWM_BITS  = 8;
  localparam int SETTLE    = 4;
  localparam int RAMP_STEP = 32;
  localparam int DEAD_TIME = 16;
  localparam int MAXD      = 255;
  localparam int PERIOD    = 256;
`ifdef SCOOT_MOTOR_BRAKE_EN
  localparam bit BRAKE_EN = 1'b1;
`else
  localparam bit BRAKE_EN = 1'b0;
`endif

  localparam int M_IDLE = 0;
  localparam int M_RAMP = 1;
  localparam int M_RUN  = 2;
  localparam int M_DEAD = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] cmd = 4'b0000;
  logic       left_pwm, left_dir, right_pwm, right_dir, left_brake, right_brake;
  logic [1:0] moving;

  always #5 clk = ~clk;

  scoot_motor_driver #(
    .PWM_BITS (PWM_BITS),
    .SETTLE   (SETTLE),
    .RAMP_STEP(RAMP_STEP),
    .DEAD_TIME(DEAD_TIME)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd        (cmd),
    .left_pwm   (left_pwm),
    .left_dir   (left_dir),
    .right_pwm  (right_pwm),
    .right_dir  (right_dir),
    .left_brake (left_brake),
    .right_brake(right_brake),
    .moving     (moving)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int model_fail_prints = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Bit order: {left_brake, right_brake, moving[1], moving[0], left_pwm, left_dir, right_pwm, right_dir}
  function automatic logic [7:0] obs();
    return {left_brake, right_brake, moving, left_pwm, left_dir, right_pwm, right_dir};
  endfunction

  // Reference model: pipeline as a delay line, filter as a window of recent samples,
  // duty derived from the number of wraps seen since ramp entry.
  logic [3:0] m_s1, m_s2, m_filt, filt_pre;
  logic [3:0] m_hist[$];
  int         m_cnt, cnt_pre;
  int         m_mode[2], m_wraps[2], m_dead[2], m_brk[2];
  bit         m_dirq[2];
  bit         all_same;
  logic [7:0] m_exp;
  bit         model_on = 1'b0;

  function automatic int duty_of(input int w);
    if (m_mode[w] == M_RUN) return MAXD;
    if (m_mode[w] == M_RAMP) return (m_wraps[w] * RAMP_STEP > MAXD) ? MAXD : m_wraps[w] * RAMP_STEP;
    return 0;
  endfunction

  task automatic wheel_step(input int w, input bit en, input bit dir, input bit wrap);
    case (m_mode[w])
      M_IDLE: begin
        if (en) begin
          m_mode[w] = M_RAMP; m_wraps[w] = 0; m_dirq[w] = dir; m_brk[w] = 0;
        end else if (m_brk[w] > 0) m_brk[w]--;
      end
      M_RAMP, M_RUN: begin
        if (!en) begin
          m_mode[w] = M_IDLE; m_brk[w] = PERIOD;
        end else if (dir != m_dirq[w]) begin
          m_mode[w] = M_DEAD; m_dead[w] = 0;
        end else if (m_mode[w] == M_RAMP && wrap) begin
          m_wraps[w]++;
          if (m_wraps[w] * RAMP_STEP >= MAXD) m_mode[w] = M_RUN;
        end
      end
      default: begin
        m_dead[w]++;
        if (m_dead[w] == DEAD_TIME) begin
          if (en) begin
            m_mode[w] = M_RAMP; m_wraps[w] = 0; m_dirq[w] = dir;
          end else m_mode[w] = M_IDLE;
        end
      end
    endcase
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_filt = 0; m_cnt = 0; m_hist.delete();
      for (int w = 0; w < 2; w++) begin
        m_mode[w] = M_IDLE; m_wraps[w] = 0; m_dead[w] = 0; m_brk[w] = 0; m_dirq[w] = 0;
      end
    end else begin
      filt_pre = m_filt;
      cnt_pre  = m_cnt;
      m_hist.push_back(m_s2);
      if (m_hist.size() > SETTLE) void'(m_hist.pop_front());
      all_same = (m_hist.size() == SETTLE);
      foreach (m_hist[i]) if (m_hist[i] != m_hist[0]) all_same = 0;
      if (all_same && m_hist[0] != m_filt) m_filt = m_hist[0];
      m_s2  = m_s1;
      m_s1  = cmd;
      m_cnt = (cnt_pre + 1) % PERIOD;
      for (int w = 0; w < 2; w++) wheel_step(w, filt_pre[2*w], filt_pre[2*w+1], cnt_pre == MAXD);
    end
    for (int w = 0; w < 2; w++) begin
      bit brk, pw, mv;
      int d;
      d   = duty_of(w);
      brk = BRAKE_EN && (m_mode[w] == M_DEAD || m_brk[w] > 0);
      pw  = ((d == MAXD) || (m_cnt < d)) && !brk;
      mv  = (m_mode[w] == M_RAMP) || (m_mode[w] == M_RUN);
      m_exp[7-w] = brk;
      m_exp[4+w] = mv;
      m_exp[3-2*w] = pw;
      m_exp[2-2*w] = m_dirq[w];
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk_cnt++;
      if (obs() === m_exp) pass_cnt++;
      else if (model_fail_prints < 50) begin
        model_fail_prints++;
        $display("FAIL model: got %b expected %b at %0t", obs(), m_exp, $time);
      end
    end
  end

  typedef struct {
    string      name;
    logic [3:0] cmd;
    int         cycles;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_len(input logic lvl, output int len);
    len = 0;
    while (left_pwm === lvl && len < 400) begin
      @(negedge clk);
      len++;
    end
  endtask

  initial begin
    int len, seg, hi;
    logic [3:0] rc;

    tbl.push_back('{"idle_hold",     4'b0000, 1000, 8'b0000_0000});
    tbl.push_back('{"glitch_in",     4'b0001, 3,    8'b0000_0000});
    tbl.push_back('{"glitch_gone",   4'b0000, 20,   8'b0000_0000});
    tbl.push_back('{"filter_delay",  4'b0011, 6,    8'b0000_0000});
    tbl.push_back('{"ramp_entry",    4'b0011, 1,    8'b0001_0100});
    tbl.push_back('{"run_left",      4'b0011, 2100, 8'b0001_1100});
    tbl.push_back('{"dead_entry",    4'b0001, 7,    {BRAKE_EN, 7'b000_0100}});
    tbl.push_back('{"dead_hold",     4'b0001, 15,   {BRAKE_EN, 7'b000_0100}});
    tbl.push_back('{"dead_exit",     4'b0001, 1,    8'b0001_0000});
    tbl.push_back('{"run_reversed",  4'b0001, 2100, 8'b0001_1000});
    tbl.push_back('{"drop_pending",  4'b0010, 6,    8'b0001_1000});
    tbl.push_back('{"drop_to_idle",  4'b0010, 1,    {BRAKE_EN, 7'b000_0000}});
    tbl.push_back('{"coast",         4'b0000, 300,  8'b0000_0000});
    tbl.push_back('{"right_ramp",    4'b1100, 7,    8'b0010_0001});
    tbl.push_back('{"both_ramp",     4'b1101, 7,    8'b0011_0001});

    repeat (3) @(negedge clk);
    check("reset_state", obs(), 8'h00);
    model_on = 1'b1;
    reset = 1'b0;

    foreach (tbl[i]) begin
      cmd = tbl[i].cmd;
      repeat (tbl[i].cycles) @(negedge clk);
      check(tbl[i].name, obs(), tbl[i].exp);
    end

    // Ramp profile: high-time of each period is the duty of that period.
    cmd = 4'b0011;
    pulse_reset();
    len = 0;
    while (left_pwm !== 1'b1 && len < 2000) begin
      @(negedge clk);
      len++;
    end
    check("ramp_start_seen", (len < 2000), 1);
    for (int k = 1; k <= 7; k++) begin
      run_len(1'b1, len);
      check($sformatf("ramp_duty_%0d", k), len, k * RAMP_STEP);
      run_len(1'b0, len);
    end
    hi = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (left_pwm === 1'b1) hi++;
    end
    check("run_constant_high", hi, 600);
    check("run_moving", moving, 2'b01);

    // Reset in the middle of a two-wheel ramp.
    cmd = 4'b1111;
    pulse_reset();
    repeat (300) @(negedge clk);
    check("pre_reset_ramping", moving, 2'b11);
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset_outputs", obs(), 8'h00);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("post_reset_filter", moving, 2'b00);
    @(negedge clk);
    check("post_reset_ramp", moving, 2'b11);

    // Random segments: short glitches, medium holds and full ramps, occasional resets.
    for (seg = 0; seg < 40; seg++) begin
      rc = 4'($urandom_range(0, 15));
      cmd = rc;
      case ($urandom_range(0, 9))
        0, 1, 2:    len = $urandom_range(1, 6);
        3, 4, 5, 6: len = $urandom_range(10, 400);
        default:    len = $urandom_range(500, 2500);
      endcase
      if ($urandom_range(0, 19) == 0) pulse_reset();
      repeat (len) @(negedge clk);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
